// File: rtl/disp_scan_mux.sv
// Multi-slot hex display scanner driving a time-multiplexed seven-segment bus.
// Optional auto paging through valid slots: define DISP_SCAN_AUTO_PAGE_EN.
module disp_scan_mux #(
  parameter int unsigned VAL_W     = 16,
  parameter int unsigned NUM_SLOTS = 8,
  parameter int unsigned SCAN_DIV  = 16,
  parameter int unsigned PAGE_DIV  = 4,
  localparam int unsigned SLOT_W   = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1,
  localparam int unsigned ND       = 2 * (VAL_W / 4)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [SLOT_W-1:0] wr_slot,
  input  logic              wr_half,
  input  logic [VAL_W-1:0]  wr_data,
  input  logic              clr,
  input  logic [SLOT_W-1:0] view_slot,
  output logic [7:0]        seg,
  output logic [ND-1:0]     seg_sel,
  output logic              frame_done,
  output logic [SLOT_W-1:0] cur_slot
);

  localparam int unsigned DPH   = VAL_W / 4;
  localparam int unsigned DIV_W = $clog2(SCAN_DIV);
  localparam int unsigned DIG_W = $clog2(ND);
  localparam logic [SLOT_W:0] SLOTS_L = (SLOT_W + 1)'(NUM_SLOTS);

  if ((VAL_W % 4) != 0 || VAL_W < 4 || NUM_SLOTS < 1 || SCAN_DIV < 2 || PAGE_DIV < 1)
  begin : g_bad_params
    $error("disp_scan_mux: illegal parameter combination");
  end

  logic [DIV_W-1:0]             div_q, div_d;
  logic [DIG_W-1:0]             dig_q, dig_d;
  logic [SLOT_W-1:0]            cur_slot_q, cur_slot_d;
  logic [7:0]                   seg_q, seg_d;
  logic [ND-1:0]                seg_sel_q, seg_sel_d;
  logic                         frame_done_q, frame_done_d;
  logic [NUM_SLOTS-1:0][1:0]    valid_q;
  logic [VAL_W-1:0]             data_q [NUM_SLOTS][2];
  logic                         wr_ok;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] p;
    unique case (n)
      4'h0: p = 7'h3F;  4'h1: p = 7'h06;  4'h2: p = 7'h5B;  4'h3: p = 7'h4F;
      4'h4: p = 7'h66;  4'h5: p = 7'h6D;  4'h6: p = 7'h7D;  4'h7: p = 7'h07;
      4'h8: p = 7'h7F;  4'h9: p = 7'h6F;  4'hA: p = 7'h77;  4'hB: p = 7'h7C;
      4'hC: p = 7'h39;  4'hD: p = 7'h5E;  4'hE: p = 7'h79;  4'hF: p = 7'h71;
    endcase
    return p;
  endfunction

  assign wr_ok = ({1'b0, wr_slot} < SLOTS_L);

  always_comb begin
    div_d = div_q;
    dig_d = dig_q;
    if (div_q == DIV_W'(SCAN_DIV - 1)) begin
      div_d = '0;
      dig_d = (dig_q == DIG_W'(ND - 1)) ? '0 : dig_q + 1'b1;
    end else begin
      div_d = div_q + 1'b1;
    end
    frame_done_d = (div_d == DIV_W'(SCAN_DIV - 1)) && (dig_d == DIG_W'(ND - 1));
  end

`ifdef DISP_SCAN_AUTO_PAGE_EN
  localparam int unsigned PAGE_W = (PAGE_DIV > 1) ? $clog2(PAGE_DIV) : 1;
  logic [PAGE_W-1:0] page_q, page_d;

  // Round-robin search for the next slot with any valid half; falls back to the current slot.
  always_comb begin
    logic              found;
    logic [SLOT_W-1:0] cand;
    found      = 1'b0;
    cand       = '0;
    page_d     = page_q;
    cur_slot_d = cur_slot_q;
    if (frame_done_q) begin
      if (page_q == PAGE_W'(PAGE_DIV - 1)) begin
        page_d = '0;
        for (int unsigned i = 1; i <= NUM_SLOTS; i++) begin
          cand = SLOT_W'((32'(cur_slot_q) + i) % NUM_SLOTS);
          if (!found && |valid_q[cand]) begin
            cur_slot_d = cand;
            found      = 1'b1;
          end
        end
      end else begin
        page_d = page_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) page_q <= '0;
    else       page_q <= page_d;
  end
`else
  assign cur_slot_d = frame_done_q ? view_slot : cur_slot_q;
`endif

  // Outputs are built from next-state counters so they line up with the divider phase.
  always_comb begin
    logic             half, slot_ok, vis;
    logic [DIG_W-1:0] sub;
    logic [VAL_W-1:0] word;
    int               shamt;
    half      = (dig_d >= DIG_W'(DPH));
    sub       = half ? dig_d - DIG_W'(DPH) : dig_d;
    slot_ok   = ({1'b0, cur_slot_d} < SLOTS_L);
    word      = '0;
    vis       = 1'b0;
    if (slot_ok) begin
      word = data_q[cur_slot_d][half];
      vis  = valid_q[cur_slot_d][half];
    end
    shamt     = 4 * (int'(DPH) - 1 - int'(sub));
    word      = word >> shamt;
    seg_d     = '0;
    seg_sel_d = '0;
    if (div_d != '0) begin
      seg_sel_d = ND'(1) << dig_d;
      if (vis) seg_d = {1'b0, hex7(word[3:0])};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      div_q        <= '0;
      dig_q        <= '0;
      cur_slot_q   <= '0;
      seg_q        <= '0;
      seg_sel_q    <= '0;
      frame_done_q <= 1'b0;
      valid_q      <= '0;
    end else begin
      div_q        <= div_d;
      dig_q        <= dig_d;
      cur_slot_q   <= cur_slot_d;
      seg_q        <= seg_d;
      seg_sel_q    <= seg_sel_d;
      frame_done_q <= frame_done_d;
      if (clr) begin
        valid_q <= '0;
      end else if (wr_en && wr_ok) begin
        valid_q[wr_slot][wr_half] <= 1'b1;
      end
    end
  end

  // Stored values survive reset; only the valid flags are cleared.
  always_ff @(posedge clock) begin
    if (!reset && wr_en && wr_ok) data_q[wr_slot][wr_half] <= wr_data;
  end

  assign seg        = seg_q;
  assign seg_sel    = seg_sel_q;
  assign frame_done = frame_done_q;
  assign cur_slot   = cur_slot_q;

endmodule

// File: tb/tb_disp_scan_mux.sv
// Directed bench for disp_scan_mux at default parameters (16-bit halves, 8 slots, 16-cycle digits).
module tb_disp_scan_mux;

  logic        clock, reset, wr_en, wr_half, clr;
  logic [2:0]  wr_slot, view_slot, cur_slot;
  logic [15:0] wr_data;
  logic [7:0]  seg, seg_sel;
  logic        frame_done;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  // Digit 0 first, one byte per digit
  localparam logic [63:0] E_BLANK = 64'h00_00_00_00_00_00_00_00;
  localparam logic [63:0] E_SLOT3 = 64'h6F_39_79_6D_3F_06_5B_4F;
  localparam logic [63:0] E_SLOT2 = 64'h71_71_71_71_00_00_00_00;

  disp_scan_mux dut (
    .clock      (clock),
    .reset      (reset),
    .wr_en      (wr_en),
    .wr_slot    (wr_slot),
    .wr_half    (wr_half),
    .wr_data    (wr_data),
    .clr        (clr),
    .view_slot  (view_slot),
    .seg        (seg),
    .seg_sel    (seg_sel),
    .frame_done (frame_done),
    .cur_slot   (cur_slot)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cyc %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic wr(input logic [2:0] slot, input logic half, input logic [15:0] data,
                    input logic do_clr);
    wr_en   = 1'b1;
    wr_slot = slot;
    wr_half = half;
    wr_data = data;
    clr     = do_clr;
    step();
    wr_en = 1'b0;
    clr   = 1'b0;
  endtask

  // Checks scan timing, segment content and frame pulse for n cycles.
  task automatic run_cycles(input int n, input logic [63:0] exp, input int slot);
    int          div, dig;
    logic [63:0] sh;
    logic [7:0]  e_sel, e_seg;
    for (int i = 0; i < n; i++) begin
      step();
      div   = cyc % 16;
      dig   = (cyc / 16) % 8;
      sh    = exp >> (8 * (7 - dig));
      e_sel = (div == 0) ? 8'h00 : (8'h01 << dig);
      e_seg = (div == 0) ? 8'h00 : sh[7:0];
      check_eq("seg_sel", 32'(seg_sel), 32'(e_sel));
      check_eq("seg", 32'(seg), 32'(e_seg));
      check_eq("frame_done", 32'(frame_done), 32'((cyc % 128) == 127));
      if ((cyc % 128) != 0) check_eq("cur_slot", 32'(cur_slot), 32'(slot));
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    step();
    cyc = 0;
    check_eq("rst_seg", 32'(seg), 32'h0);
    check_eq("rst_seg_sel", 32'(seg_sel), 32'h0);
    check_eq("rst_frame_done", 32'(frame_done), 32'h0);
    check_eq("rst_cur_slot", 32'(cur_slot), 32'h0);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_slot = '0; wr_half = 1'b0; wr_data = '0;
    clr = 1'b0; view_slot = '0;
    step();
    apply_reset();

`ifdef DISP_SCAN_AUTO_PAGE_EN
    wr(3'd1, 1'b0, 16'h1111, 1'b0);
    wr(3'd5, 1'b1, 16'h5555, 1'b0);
    run_cycles(509, E_BLANK, 0);
    step();
    check_eq("page_to_1", 32'(cur_slot), 32'd1);
    run_cycles(511, 64'h06_06_06_06_00_00_00_00, 1);
    step();
    check_eq("page_to_5", 32'(cur_slot), 32'd5);
    run_cycles(511, 64'h00_00_00_00_6D_6D_6D_6D, 5);
    step();
    check_eq("page_wrap_1", 32'(cur_slot), 32'd1);
`else
    // Idle frame: nothing valid, seg_sel still scans
    run_cycles(127, E_BLANK, 0);
    step();
    check_eq("idle_cur", 32'(cur_slot), 32'd0);

    view_slot = 3'd3;
    wr(3'd3, 1'b0, 16'h9CE5, 1'b0);
    wr(3'd3, 1'b1, 16'h0123, 1'b0);
    run_cycles(125, E_BLANK, 0);
    step();
    check_eq("view3_cur", 32'(cur_slot), 32'd3);
    run_cycles(127, E_SLOT3, 3);
    step();

    // Only half 0 of slot 2 valid
    view_slot = 3'd2;
    wr(3'd2, 1'b0, 16'hFFFF, 1'b0);
    run_cycles(126, E_SLOT3, 3);
    step();
    check_eq("view2_cur", 32'(cur_slot), 32'd2);
    run_cycles(127, E_SLOT2, 2);
    step();

    // Mid-frame view change takes effect only after frame_done
    run_cycles(40, E_SLOT2, 2);
    view_slot = 3'd3;
    run_cycles(87, E_SLOT2, 2);
    step();
    check_eq("switch_cur", 32'(cur_slot), 32'd3);
    check_eq("switch_seg", 32'(seg), 32'h0);
    run_cycles(127, E_SLOT3, 3);
    step();

    // clr beats a simultaneous write; out-of-range-free slot 4 stays blank
    view_slot = 3'd4;
    wr(3'd4, 1'b0, 16'h1234, 1'b1);
    run_cycles(126, E_BLANK, 3);
    step();
    check_eq("clr_cur", 32'(cur_slot), 32'd4);
    run_cycles(188, E_BLANK, 4);

    // Reset mid-frame restarts the scan at digit 0
    apply_reset();
    run_cycles(40, E_BLANK, 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/disp_scan_mux.md
Name: disp_scan_mux

Overview:
- Parametrised successor to the fixed 8-digit hex output stage.
- Stores NUM_SLOTS register slots; each slot holds two VAL_W-bit halves with per-half valid flags.
- Shows one selected slot on a time-multiplexed common seven-segment bus: one segment bus plus one-hot digit select, with a blanking gap between digits.
- Sits between the datapath debug/result taps and the board LED pins.

Parameters:
- VAL_W, 16, width of each half; must be a multiple of 4. Digits per half DPH = VAL_W/4; total digits ND = 2*DPH.
- NUM_SLOTS, 8, number of stored slots, >=1; SLOT_W = max(1, clog2(NUM_SLOTS)).
- SCAN_DIV, 16, clock cycles per digit, >=2.
- PAGE_DIV, 4, scan frames per auto-page step; used only with the optional feature.

Ports:
- clock, in, 1: single clock, rising edge.
- reset, in, 1: synchronous, active-high.
- wr_en, in, 1: write strobe.
- wr_slot, in, SLOT_W: target slot.
- wr_half, in, 1: 0 = half 0 (left digits), 1 = half 1 (right digits).
- wr_data, in, VAL_W: value to store.
- clr, in, 1: clears all valid flags.
- view_slot, in, SLOT_W: slot to display (manual mode).
- seg, out, 8: segment pattern, active-high, bit order {dp,g,f,e,d,c,b,a}.
- seg_sel, out, ND: one-hot digit enable, active-high.
- frame_done, out, 1: one-cycle pulse when the last digit's period ends.
- cur_slot, out, SLOT_W: slot currently displayed.

Behaviour:
- Reset (synchronous, reset high at a rising edge):
  - seg=0, seg_sel=0, frame_done=0, cur_slot=0.
  - Digit index=0, divider=0, page counters=0, all valid flags=0.
  - Stored data is not cleared.
  - Reset asserted mid-scan or mid-write aborts the operation; the write is dropped.
- Storage write:
  - When wr_en=1 and wr_slot<NUM_SLOTS, data[wr_slot][wr_half] <= wr_data and valid[wr_slot][wr_half] <= 1.
  - When wr_slot>=NUM_SLOTS the write is ignored.
  - clr=1 clears every valid flag at that edge. If clr and wr_en arrive together, clr wins and the write's valid flag stays 0.
- Scan counter:
  - Divider counts 0..SCAN_DIV-1.
  - At divider==SCAN_DIV-1: divider wraps to 0 and digit index advances mod ND.
  - frame_done=1 for exactly that cycle when the digit index wraps ND-1 -> 0.
- Digit mapping:
  - Digit d<DPH shows half 0, nibble bits [VAL_W-1-4d -: 4], so digit 0 is the MSB nibble.
  - Digit d>=DPH shows half 1 with the same rule using d-DPH.
- Outputs are registered and computed from the current digit index and the stored contents.
  - Divider==0 (first cycle of each digit) is a blanking cycle: seg=0, seg_sel=0.
  - Otherwise seg_sel=one-hot(digit index) and seg=hex pattern of the nibble.
  - Latency: a write at edge N appears on seg from edge N+1 onward, whenever that digit is active.
- Hex patterns: 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71. dp is always 0.
- Invalid half: seg=00 for that half's digits, but seg_sel still strobes so scan timing is unchanged.
- Manual mode: cur_slot follows view_slot, sampled only at frame_done so a frame is never torn. If view_slot>=NUM_SLOTS, the whole display is blanked (seg=00).

Optional Feature:
- Macro: DISP_SCAN_AUTO_PAGE_EN.
- Defined:
  - view_slot is ignored.
  - After every PAGE_DIV frame_done pulses, cur_slot advances to the next slot (mod NUM_SLOTS) having at least one valid half. Slots with no valid half are skipped.
  - If no slot is valid, cur_slot stays put and the display is blank.
  - Switching happens only at the frame boundary.
- Not defined: manual mode only; page counter logic is absent.

Test Plan:
- Reset, then run: seg_sel steps 01,02,04..80, each held SCAN_DIV-1=15 cycles after a 1-cycle blank; seg=00 throughout (nothing valid); frame_done pulses every 128 cycles.
- Write slot 3 half 0 = 16'h9CE5, half 1 = 16'h0123, view_slot=3: digit 0..7 show 6F,39,79,6D,3F,06,5B,4F.
- Write slot 2 half 0 = 16'hFFFF only, view_slot=2: digits 0-3 show 71, digits 4-7 show 00 while seg_sel still strobes 10..80.
- Change view_slot mid-frame: cur_slot and seg content change only on the cycle after frame_done.
- wr_en and clr in the same cycle: valid stays 0 and the display is blank. Then assert reset mid-frame: next cycle seg=0, seg_sel=0, digit index restarts at 0.
- With DISP_SCAN_AUTO_PAGE_EN, slots 1 and 5 valid, PAGE_DIV=4: cur_slot goes 0 -> 1 -> 5 -> 1, changing every 4 frames.
